// File: rtl/code_select_arbiter.sv
// Run-time selectable fixed-priority / round-robin arbiter that picks one of N_CH
// demux address codes and registers it into a single valid/ready output slot.
module code_select_arbiter #(
  parameter int CODE_W = 4,
  parameter int N_CH   = 4,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*CODE_W-1:0]   req_code,
  output logic [N_CH-1:0]          req_ready,
  input  logic                     mode,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        code_out,
  output logic [CH_W-1:0]          ch_out,
  output logic                     out_valid
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic              r_state;
  logic [CODE_W-1:0] r_code;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_rr_ptr;

  logic              w_slot_free;
  logic              w_grant;
  logic [CH_W-1:0]   w_fp_win;
  logic [N_CH-1:0]   w_rr_vec;
  logic [CH_W-1:0]   w_rr_off;
  logic [CH_W:0]     w_rr_sum;
  logic [CH_W-1:0]   w_rr_win;
  logic [CH_W-1:0]   w_win;
  logic [CH_W-1:0]   w_ptr_next;
  logic [CODE_W-1:0] w_win_code;

  function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] vec);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = CH_W'(i);
    end
  endfunction

  assign w_slot_free = (r_state == ST_EMPTY) | out_ready;
  // Reset gates the grant so no requester sees an acceptance while in reset.
  assign w_grant     = reset_n & w_slot_free & (|req_valid);

  assign w_fp_win = lowest_set(req_valid);

  // Rotate so rr_ptr lands at bit 0, find the first request, then map back.
  assign w_rr_vec = N_CH'({req_valid, req_valid} >> r_rr_ptr);
  assign w_rr_off = lowest_set(w_rr_vec);
  assign w_rr_sum = {1'b0, r_rr_ptr} + {1'b0, w_rr_off};
  assign w_rr_win = (w_rr_sum >= (CH_W+1)'(N_CH)) ?
                    CH_W'(w_rr_sum - (CH_W+1)'(N_CH)) : w_rr_sum[CH_W-1:0];

  assign w_win      = mode ? w_rr_win : w_fp_win;
  assign w_ptr_next = (w_win == CH_W'(N_CH - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_win_code = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_win == CH_W'(i)) w_win_code = req_code[i*CODE_W +: CODE_W];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_ready[i] = w_grant & (w_win == CH_W'(i));
    end
  end

  // Output slot register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_EMPTY;
      r_code   <= '0;
      r_ch     <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_state  <= ST_FULL;
      r_code   <= w_win_code;
      r_ch     <= w_win;
      r_rr_ptr <= w_ptr_next;
    end else if (out_ready) begin
      r_state  <= ST_EMPTY;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign code_out  = r_code;
  assign ch_out    = r_ch;

endmodule

// File: tb/tb_code_select_arbiter.sv
// Randomized and directed bench for code_select_arbiter against a cycle-level
// reference model of the arbitration rules and output slot.
module tb_code_select_arbiter;
  localparam int CODE_W = 4;
  localparam int N_CH   = 4;
  localparam int CH_W   = 2;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N_CH-1:0]        req_valid;
  logic [N_CH*CODE_W-1:0] req_code;
  logic [N_CH-1:0]        req_ready;
  logic                   mode;
  logic                   out_ready;
  logic [CODE_W-1:0]      code_out;
  logic [CH_W-1:0]        ch_out;
  logic                   out_valid;

  int errors = 0;
  int checks = 0;

  logic              m_valid;
  logic [CODE_W-1:0] m_code;
  int                m_ch;
  int                m_ptr;

  code_select_arbiter #(.CODE_W(CODE_W), .N_CH(N_CH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .mode      (mode),
    .out_ready (out_ready),
    .code_out  (code_out),
    .ch_out    (ch_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CODE_W-1:0] code_of(input int ch);
    logic [CODE_W-1:0] c;
    c = '0;
    for (int b = 0; b < CODE_W; b++) c[b] = req_code[ch*CODE_W + b];
    return c;
  endfunction

  task automatic set_code(input int ch, input logic [CODE_W-1:0] c);
    for (int b = 0; b < CODE_W; b++) req_code[ch*CODE_W + b] = c[b];
  endtask

  // Winner per the arbitration rules, or -1 when nothing is accepted.
  function automatic int model_winner();
    int idx;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N_CH; k++) begin
      idx = (mode == 1'b0) ? k : (m_ptr + k) % N_CH;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_code  = '0;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  // Check outputs mid-cycle, then advance the model at the rising edge.
  task automatic cycle_check(output int w);
    @(negedge clk);
    w = model_winner();
    check("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("code_out", 32'(code_out), 32'(m_code));
    check("ch_out", 32'(ch_out), 32'(m_ch));
    @(posedge clk);
    if (w >= 0) begin
      m_valid = 1'b1;
      m_code  = code_of(w);
      m_ch    = w;
      m_ptr   = (w + 1) % N_CH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int w;
    logic [CODE_W-1:0] rr_exp [5];
    rr_exp = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    reset_n   = 1'b0;
    req_valid = '0;
    req_code  = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    do_reset();

    // Idle after reset
    cycle_check(w);
    check("rst_code", 32'(code_out), 32'd0);

    // Fixed priority picks ch1 over ch3
    req_valid = 4'b1010;
    set_code(1, 4'h5);
    set_code(3, 4'hC);
    out_ready = 1'b1;
    #1 check("fp_ready", 32'(req_ready), 32'b0010);
    cycle_check(w);
    req_valid = 4'b0000;
    #1 check("fp_code", 32'(code_out), 32'h5);
    check("fp_ch", 32'(ch_out), 32'd1);

    // Round-robin walk with wrap
    do_reset();
    mode = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < N_CH; i++) set_code(i, CODE_W'(i + 1));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle_check(w);
      check($sformatf("rr_seq%0d", i), 32'(code_out), 32'(rr_exp[i]));
    end

    // Back-pressure then no-bubble handoff
    do_reset();
    mode = 1'b0;
    req_valid = 4'b0100;
    set_code(2, 4'h9);
    out_ready = 1'b1;
    cycle_check(w);
    req_valid = 4'b0001;
    set_code(0, 4'h7);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_check(w);
      check("bp_code", 32'(code_out), 32'h9);
      check("bp_ch", 32'(ch_out), 32'd2);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b0001);
    cycle_check(w);
    req_valid = 4'b0000;
    check("handoff_code", 32'(code_out), 32'h7);
    check("handoff_valid", 32'(out_valid), 32'd1);

    // Drain keeps the last code
    cycle_check(w);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_code", 32'(code_out), 32'h7);

    // Asynchronous reset while FULL and stalled
    req_valid = 4'b0010;
    set_code(1, 4'h3);
    out_ready = 1'b1;
    cycle_check(w);
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("async_valid", 32'(out_valid), 32'd0);
    check("async_code", 32'(code_out), 32'd0);
    check("async_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b1100;
    #1 check("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    mode = 1'b1;
    out_ready = 1'b1;
    set_code(2, 4'hA);
    set_code(3, 4'hB);
    cycle_check(w);
    check("post_rst_ch", 32'(ch_out), 32'd2);

    // Randomized traffic; requesters hold until accepted
    req_valid = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        if (!req_valid[ch] && $urandom_range(0, 2) == 0) begin
          req_valid[ch] = 1'b1;
          set_code(ch, CODE_W'($urandom));
        end
      end
      cycle_check(w);
      if (w >= 0) req_valid[w] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_select_arbiter.md
Name: code_select_arbiter

Overview:
- N-channel successor to the 2:1 demux-code multiplexer.
- Arbitrates among N_CH requesters, each presenting a CODE_W-bit demux address, and registers the winning code onto a single output for the downstream demux.
- Output uses a valid/ready handshake.
- Arbitration mode is selectable at run time: fixed priority or round-robin.

Parameters:
- CODE_W, 4: width of each demux address code.
- N_CH, 4: number of requesting channels; legal values are 2 to 16.
- CH_W, $clog2(N_CH): width of the granted-channel index; the minimum is 1.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- req_valid, input, N_CH: bit i asserts channel i has a code pending.
- req_code, input, N_CH*CODE_W: channel i code occupies bits [i*CODE_W +: CODE_W].
- req_ready, output, N_CH: one-hot or zero; bit i means channel i's code is accepted this cycle. Combinational.
- mode, input, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- out_ready, input, 1: the downstream demux consumes the current code.
- code_out, output, CODE_W: registered selected code.
- ch_out, output, CH_W: registered index of the channel that supplied code_out.
- out_valid, output, 1: code_out and ch_out are valid.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_valid=0, code_out=0, ch_out=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is forced to 0 while reset is asserted.
- Output slot:
  - Single register stage. slot_free = !out_valid | out_ready.
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on a grant with out_ready=1 (back-to-back transfer).
  - FULL -> EMPTY when out_ready=1 and there is no grant.
  - FULL holds when out_ready=0.
- Grant:
  - When slot_free=1 and |req_valid, exactly one req_ready bit asserts for winner w, in the same cycle.
  - At the next rising edge: code_out <= req_code[w], ch_out <= w, out_valid <= 1.
  - Latency is 1 cycle from acceptance to out_valid.
  - When slot_free=0, req_ready=0.
  - req_ready never asserts for a channel whose req_valid=0.
- Fixed priority (mode=0): w = the lowest index i with req_valid[i]=1.
- Round-robin (mode=1):
  - Search starts at rr_ptr and wraps modulo N_CH; w is the first set bit found.
  - On every grant in either mode, rr_ptr <= (w+1) mod N_CH. If w = N_CH-1, rr_ptr wraps to 0.
  - rr_ptr does not change without a grant.
- Stability:
  - While out_valid=1 and out_ready=0, code_out and ch_out hold their values.
  - On FULL -> EMPTY, code_out and ch_out keep their last values.
- Mode change: takes effect for the next grant decision (the same-cycle combinational decision). rr_ptr is preserved across mode changes.
- Requester rule: a requester must hold req_valid and req_code until it sees req_ready. The block does not check this.
- Reset mid-operation: a pending output is discarded (out_valid=0 immediately). Outputs return to reset values regardless of out_ready.
- Simultaneous events: if out_ready=1 and a grant occur in the same cycle, the old code is consumed and the new code is loaded at the same edge. There is no bubble.

Test Plan:
- Reset, then release; req_valid=0 -> out_valid=0, code_out=0, ch_out=0, req_ready=0000.
- mode=0; req_valid=1010, ch1 code 4'h5, ch3 code 4'hC; out_ready=1 -> req_ready=0010 in that cycle; next cycle code_out=5, ch_out=1.
- mode=1 from reset; all four channels valid with codes 1,2,3,4; out_ready=1 for 5 cycles -> grants in order ch0, ch1, ch2, ch3, ch0, producing code_out sequence 1,2,3,4,1. Confirms wrap-around of rr_ptr.
- Back-pressure: load code 4'h9 from ch2; hold out_ready=0 for 3 cycles while ch0 is requesting -> code_out stays 9, ch_out stays 2, req_ready=0. Raise out_ready -> ch0 is granted the same cycle and its code appears on the next edge with no bubble.
- Drain: out_valid=1, out_ready=1, no requests -> out_valid=0 next cycle, code_out holds its value.
- Assert reset_n=0 mid-cycle while FULL with out_ready=0 -> out_valid drops asynchronously; after release, the first round-robin grant goes to the lowest valid index ≥0.
